// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core widths, reset PC and fetch FSM state encodings
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [7:0] RESET_PC = 8'h00;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/gnt/rvalid bus
interface fetch_stage_if #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) ();
    import cpu_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {instr, pc} buffer parking a response during a decode stall
module fetch_hold_buf #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    // Clear/unload win over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and single-outstanding instruction fetch feeding the IF/ID register
module fetch_stage #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    fetch_stage_if.master      imem,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc
);
    import cpu_pkg::*;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;

    logic               hb_load, hb_unload, hb_clear, hb_valid;
    logic [INSTR_W-1:0] hb_instr;
    logic [PC_W-1:0]    hb_pc;

    fetch_hold_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (hb_load),
        .unload_i (hb_unload),
        .clear_i  (hb_clear),
        .instr_i  (imem.imem_rdata),
        .pc_i     (pc_q),
        .valid_o  (hb_valid),
        .instr_o  (hb_instr),
        .pc_o     (hb_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_valid_d = stall ? if_id_valid_q : 1'b0;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        hb_load       = 1'b0;
        hb_unload     = 1'b0;
        hb_clear      = 1'b0;

        if (redirect_valid) begin
            // A request already accepted for the old path must be drained in S_DROP.
            pc_d          = redirect_pc;
            if_id_valid_d = 1'b0;
            hb_clear      = 1'b1;
            case (state_q)
                S_REQ:   state_d = imem.imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem.imem_rvalid ? S_REQ  : S_DROP;
                S_HOLD:  state_d = S_REQ;
                default: state_d = imem.imem_rvalid ? S_REQ  : S_DROP;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem.imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!stall) begin
                            if_id_valid_d = 1'b1;
                            if_id_instr_d = imem.imem_rdata;
                            if_id_pc_d    = pc_q;
                            pc_d          = pc_q + 1'b1;
                            state_d       = S_REQ;
                        end else begin
                            hb_load = 1'b1;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && hb_valid) begin
                        if_id_valid_d = 1'b1;
                        if_id_instr_d = hb_instr;
                        if_id_pc_d    = hb_pc;
                        hb_unload     = 1'b1;
                        pc_d          = pc_q + 1'b1;
                        state_d       = S_REQ;
                    end
                end
                default: begin
                    if (imem.imem_rvalid) state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

    // Reset leaves state at S_REQ, so the request is masked while rst is held.
    assign imem.imem_req  = (state_q == S_REQ) && !rst;
    assign imem.imem_addr = pc_q;

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;

    fetch_stage_if #(.PC_W(8), .INSTR_W(16)) imem_bus ();

    fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] sb[$];
    logic [23:0] exp_e = '0;
    logic        stall_edge;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // Compare each new IF/ID load against the oldest expected entry.
    always @(posedge clk) begin
        stall_edge = stall;
        #1;
        if (!rst && if_id_valid && !stall_edge) begin
            if (sb.size() == 0) begin
                chk("sb_has_entry", sb.size(), 1);
            end else begin
                exp_e = sb.pop_front();
                chk("sb_instr", if_id_instr, exp_e[23:8]);
                chk("sb_pc", if_id_pc, exp_e[7:0]);
            end
        end
    end

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            if (imem_bus.imem_req) return;
            @(negedge clk);
        end
        chk("req_timeout", imem_bus.imem_req, 1);
    endtask

    task automatic do_fetch(input logic [7:0] a, input logic [15:0] d,
                            input int gdly, input int lat, input int stall_n);
        wait_req();
        for (int i = 0; i < gdly; i++) begin
            chk("addr_stable", imem_bus.imem_addr, a);
            @(negedge clk);
        end
        chk("req_addr", imem_bus.imem_addr, a);
        chk("req_high", imem_bus.imem_req, 1);
        imem_bus.imem_gnt = 1'b1;
        @(negedge clk);
        imem_bus.imem_gnt = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk("wait_no_req", imem_bus.imem_req, 0);
            @(negedge clk);
        end
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = d;
        sb.push_back({d, a});
        if (stall_n > 0) stall = 1'b1;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = '0;
        if (stall_n > 0) begin
            for (int i = 1; i < stall_n; i++) begin
                chk("stall_valid", if_id_valid, 0);
                chk("stall_pc", if_id_pc, exp_e[7:0]);
                chk("stall_instr", if_id_instr, exp_e[23:8]);
                @(negedge clk);
            end
            stall = 1'b0;
            @(negedge clk);
        end
        chk("deliver_valid", if_id_valid, 1);
        chk("deliver_pc", if_id_pc, a);
        chk("deliver_instr", if_id_instr, d);
    endtask

    task automatic redirect_idle(input logic [7:0] t);
        wait_req();
        redirect_valid = 1'b1;
        redirect_pc    = t;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_idle_addr", imem_bus.imem_addr, t);
        chk("redir_idle_req", imem_bus.imem_req, 1);
        chk("redir_idle_valid", if_id_valid, 0);
    endtask

    initial begin
        rst                  = 1'b1;
        stall                = 1'b0;
        redirect_valid       = 1'b0;
        redirect_pc          = '0;
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_bus.imem_req, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr, 0);
        chk("rst_pc", if_id_pc, 0);
        rst = 1'b0;
        #1;
        chk("first_req", imem_bus.imem_req, 1);
        chk("first_addr", imem_bus.imem_addr, 0);

        do_fetch(8'h00, 16'hD2A0, 0, 1, 0);
        do_fetch(8'h01, mdata(8'h01), 2, 1, 0);
        do_fetch(8'h02, mdata(8'h02), 0, 3, 0);
        do_fetch(8'h03, mdata(8'h03), 1, 2, 0);
        do_fetch(8'h04, mdata(8'h04), 0, 1, 0);
        do_fetch(8'h05, 16'h1234, 0, 1, 3);
        do_fetch(8'h06, mdata(8'h06), 0, 1, 0);

        // Redirect while the 0x10 response is outstanding.
        redirect_idle(8'h10);
        imem_bus.imem_gnt = 1'b1;
        @(negedge clk);
        imem_bus.imem_gnt = 1'b0;
        redirect_valid    = 1'b1;
        redirect_pc       = 8'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("drop_req", imem_bus.imem_req, 0);
        chk("drop_valid", if_id_valid, 0);
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = 16'hBAD0;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        chk("drop_after_valid", if_id_valid, 0);
        chk("drop_after_req", imem_bus.imem_req, 1);
        chk("drop_after_addr", imem_bus.imem_addr, 8'h40);
        do_fetch(8'h40, mdata(8'h40), 0, 1, 0);

        // Redirect, stall and rvalid all in one cycle.
        wait_req();
        chk("rsr_addr", imem_bus.imem_addr, 8'h41);
        stall             = 1'b1;
        imem_bus.imem_gnt = 1'b1;
        @(negedge clk);
        imem_bus.imem_gnt = 1'b0;
        chk("rsr_pre_valid", if_id_valid, 1);
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = 16'hBEEF;
        redirect_valid       = 1'b1;
        redirect_pc          = 8'h20;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        redirect_valid       = 1'b0;
        chk("rsr_valid", if_id_valid, 0);
        chk("rsr_req", imem_bus.imem_req, 1);
        chk("rsr_addr_next", imem_bus.imem_addr, 8'h20);
        stall = 1'b0;
        do_fetch(8'h20, mdata(8'h20), 0, 1, 0);

        redirect_idle(8'hFF);
        do_fetch(8'hFF, mdata(8'hFF), 0, 1, 0);
        do_fetch(8'h00, mdata(8'h00), 0, 2, 0);

        // Asynchronous reset while waiting for a response.
        wait_req();
        stall             = 1'b1;
        imem_bus.imem_gnt = 1'b1;
        @(negedge clk);
        imem_bus.imem_gnt = 1'b0;
        chk("pre_rst_valid", if_id_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", if_id_valid, 0);
        chk("async_rst_req", imem_bus.imem_req, 0);
        chk("async_rst_pc", if_id_pc, 0);
        @(negedge clk);
        chk("held_rst_req", imem_bus.imem_req, 0);
        stall = 1'b0;
        rst   = 1'b0;
        #1;
        chk("post_rst_req", imem_bus.imem_req, 1);
        chk("post_rst_addr", imem_bus.imem_addr, 8'h00);
        do_fetch(8'h00, 16'hD2A0, 0, 1, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
